handshake_watchdog: RTL and testbench

- Sits directly upstream of the supervisor, between the uP handshake pins and the supervisor inputs.
- Synchronises the uP 4-phase handshake pair (uP_handshake_1 = request from uP, uP_handshake_2 = acknowledge from FPGA).
- Tracks protocol phase, times out stalled phases, latches a fault code and counts completed transactions.
- Clean, synchronised handshake copies plus fault status feed the supervisor for LED display.

---
 rtl/handshake_watchdog_pkg.sv | 28 ++
 rtl/handshake_watchdog_sync_bit.sv | 30 +++
 rtl/handshake_watchdog.sv | 203 ++++++++++++++++++++
 tb/tb_handshake_watchdog.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_watchdog_pkg.sv
// rtl/handshake_watchdog_pkg.sv - shared types and constants for the handshake watchdog
//
// Purpose: phase and fault-code encodings plus the default timeout, shared by
// the watchdog top and its bench.
package handshake_watchdog_pkg;

  // 1 ms at 50 MHz
  localparam int HS_TIMEOUT_DEFAULT = 50000;

  typedef enum logic [2:0] {
    HS_IDLE         = 3'd0,
    HS_WAIT_ACK     = 3'd1,
    HS_WAIT_REQ_LOW = 3'd2,
    HS_WAIT_ACK_LOW = 3'd3,
    HS_FAULT        = 3'd4
  } hs_phase_t;

  typedef enum logic [2:0] {
    FLT_NONE          = 3'd0,
    FLT_SPURIOUS_ACK  = 3'd1,
    FLT_REQ_WITHDRAWN = 3'd2,
    FLT_ACK_EARLY     = 3'd3,
    FLT_TO_ACK        = 3'd4,
    FLT_TO_REQ_LOW    = 3'd5,
    FLT_TO_ACK_LOW    = 3'd6
  } hs_fault_t;

endpackage

// File: rtl/handshake_watchdog_sync_bit.sv
// rtl/handshake_watchdog_sync_bit.sv - multi-flop synchroniser for one asynchronous bit
//
// Purpose: STAGES-deep flip-flop chain bringing an asynchronous level into clk.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, clears the chain
//   d_i  - asynchronous input level
//   q_o  - synchronised level (last stage), STAGES cycles of latency
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/handshake_watchdog.sv
// rtl/handshake_watchdog.sv - 4-phase handshake synchroniser, protocol checker and watchdog
//
// Purpose: synchronises the uP request/acknowledge pair, tracks the 4-phase
// protocol, times out stalled phases, latches a fault code and counts
// completed transactions.
// Optional feature: define HS_WATCHDOG_LOG_EN to add a 4-deep fault log.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   uP_handshake_1    - raw request (asynchronous)
//   uP_handshake_2    - raw acknowledge (asynchronous)
//   fault_clear       - one-cycle pulse clearing a latched fault
//   hs_req_sync       - synchronised request
//   hs_ack_sync       - synchronised acknowledge
//   fault             - latched fault flag
//   fault_code        - cause of latched fault, 0 when no fault
//   phase             - current protocol phase
//   trans_count       - completed handshakes, wraps
//   log_rd/log_data/log_empty - fault log pop, head entry {code, count}, empty
//                       flag (HS_WATCHDOG_LOG_EN only)
module handshake_watchdog
  import handshake_watchdog_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = HS_TIMEOUT_DEFAULT,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   uP_handshake_1,
  input  logic                   uP_handshake_2,
  input  logic                   fault_clear,
`ifdef HS_WATCHDOG_LOG_EN
  input  logic                   log_rd,
  output logic [COUNT_WIDTH+2:0] log_data,
  output logic                   log_empty,
`endif
  output logic                   hs_req_sync,
  output logic                   hs_ack_sync,
  output logic                   fault,
  output logic [2:0]             fault_code,
  output logic [2:0]             phase,
  output logic [COUNT_WIDTH-1:0] trans_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic req_s, ack_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk (clk),
    .rst (reset),
    .d_i (uP_handshake_1),
    .q_o (req_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk (clk),
    .rst (reset),
    .d_i (uP_handshake_2),
    .q_o (ack_s)
  );

  hs_phase_t              state_q, state_d;
  hs_fault_t              code_q, code_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HS_IDLE;
      code_q  <= FLT_NONE;
      timer_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      timer_q <= timer_d;
      count_q <= count_d;
    end
  end

  // Within each wait phase the legal transition is tested first so that it
  // beats both a protocol violation and a timer expiry on the same cycle.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    count_d = count_q;
    timer_d = '0;
    expired = (timer_q == TW'(TIMEOUT_CYCLES - 1));
    case (state_q)
      HS_IDLE: begin
        if (ack_s) begin
          state_d = HS_FAULT;
          code_d  = FLT_SPURIOUS_ACK;
        end else if (req_s) begin
          state_d = HS_WAIT_ACK;
        end
      end
      HS_WAIT_ACK: begin
        if (ack_s) begin
          state_d = HS_WAIT_REQ_LOW;
        end else if (!req_s) begin
          state_d = HS_FAULT;
          code_d  = FLT_REQ_WITHDRAWN;
        end else if (expired) begin
          state_d = HS_FAULT;
          code_d  = FLT_TO_ACK;
        end
      end
      HS_WAIT_REQ_LOW: begin
        if (!req_s) begin
          state_d = HS_WAIT_ACK_LOW;
        end else if (!ack_s) begin
          state_d = HS_FAULT;
          code_d  = FLT_ACK_EARLY;
        end else if (expired) begin
          state_d = HS_FAULT;
          code_d  = FLT_TO_REQ_LOW;
        end
      end
      HS_WAIT_ACK_LOW: begin
        if (!ack_s) begin
          state_d = HS_IDLE;
          count_d = count_q + 1'b1;
        end else if (req_s) begin
          state_d = HS_FAULT;
          code_d  = FLT_ACK_EARLY;
        end else if (expired) begin
          state_d = HS_FAULT;
          code_d  = FLT_TO_ACK_LOW;
        end
      end
      HS_FAULT: begin
        // Leaving FAULT with either line still high would immediately
        // misread the next phase, so the clear is only honoured when quiet.
        if (fault_clear && !req_s && !ack_s) begin
          state_d = HS_IDLE;
          code_d  = FLT_NONE;
        end
      end
      default: begin
        state_d = HS_IDLE;
        code_d  = FLT_NONE;
      end
    endcase
    // Timer runs only while sitting in an unchanged wait phase.
    if ((state_d == state_q) && (state_q != HS_IDLE) && (state_q != HS_FAULT)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_comb begin
    hs_req_sync = req_s;
    hs_ack_sync = ack_s;
    fault       = (state_q == HS_FAULT);
    fault_code  = code_q;
    phase       = state_q;
    trans_count = count_q;
  end

`ifdef HS_WATCHDOG_LOG_EN
  logic [COUNT_WIDTH+2:0] log_mem_q [4];
  logic [1:0]             wr_ptr_q, rd_ptr_q;
  logic [2:0]             log_cnt_q;
  logic                   log_wr, log_pop, log_full;

  assign log_wr   = (state_d == HS_FAULT) && (state_q != HS_FAULT);
  assign log_full = (log_cnt_q == 3'd4);
  assign log_pop  = log_rd && (log_cnt_q != 3'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      log_cnt_q <= '0;
    end else begin
      if (log_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      // A write into a full log drops the oldest entry by moving the head.
      if (log_pop || (log_wr && log_full)) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (log_wr && !log_pop && !log_full) begin
        log_cnt_q <= log_cnt_q + 1'b1;
      end else if (log_pop && !log_wr) begin
        log_cnt_q <= log_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (log_wr) begin
      log_mem_q[wr_ptr_q] <= {code_d, count_q};
    end
  end

  assign log_data  = log_mem_q[rd_ptr_q];
  assign log_empty = (log_cnt_q == 3'd0);
`endif

endmodule

// File: tb/tb_handshake_watchdog.sv
// tb/tb_handshake_watchdog.sv - directed self-checking bench for handshake_watchdog
module tb_handshake_watchdog;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          uP_handshake_1, uP_handshake_2, fault_clear;
  logic          hs_req_sync, hs_ack_sync, fault;
  logic [2:0]    fault_code, phase;
  logic [CW-1:0] trans_count;
`ifdef HS_WATCHDOG_LOG_EN
  logic          log_rd;
  logic [CW+2:0] log_data;
  logic          log_empty;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  handshake_watchdog #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (100),
    .COUNT_WIDTH    (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .uP_handshake_1 (uP_handshake_1),
    .uP_handshake_2 (uP_handshake_2),
    .fault_clear    (fault_clear),
`ifdef HS_WATCHDOG_LOG_EN
    .log_rd         (log_rd),
    .log_data       (log_data),
    .log_empty      (log_empty),
`endif
    .hs_req_sync    (hs_req_sync),
    .hs_ack_sync    (hs_ack_sync),
    .fault          (fault),
    .fault_code     (fault_code),
    .phase          (phase),
    .trans_count    (trans_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_pulse();
    fault_clear = 1'b1;
    cyc(1);
    fault_clear = 1'b0;
  endtask

  // Each edge of the handshake takes 2 sync cycles plus 1 FSM cycle.
  task automatic handshake();
    uP_handshake_1 = 1'b1; cyc(3);
    uP_handshake_2 = 1'b1; cyc(3);
    uP_handshake_1 = 1'b0; cyc(3);
    uP_handshake_2 = 1'b0; cyc(3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  initial begin
    reset = 1'b1;
    uP_handshake_1 = 1'b0;
    uP_handshake_2 = 1'b0;
    fault_clear = 1'b0;
`ifdef HS_WATCHDOG_LOG_EN
    log_rd = 1'b0;
`endif
    cyc(2);
    reset = 1'b0;
    cyc(1);
    chk("rst_phase", phase, 0);
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
    chk("rst_count", trans_count, 0);
    chk("rst_req_sync", hs_req_sync, 0);

    // Clean handshake
    uP_handshake_1 = 1'b1;
    cyc(2);
    chk("clean_req_sync", hs_req_sync, 1);
    chk("clean_still_idle", phase, 0);
    cyc(1);
    chk("clean_wait_ack", phase, 1);
    cyc(9);
    uP_handshake_2 = 1'b1;
    cyc(2);
    chk("clean_ack_sync", hs_ack_sync, 1);
    chk("clean_ack_pending", phase, 1);
    cyc(1);
    chk("clean_wait_req_low", phase, 2);
    uP_handshake_1 = 1'b0;
    cyc(3);
    chk("clean_wait_ack_low", phase, 3);
    uP_handshake_2 = 1'b0;
    cyc(2);
    chk("clean_count_before", trans_count, 0);
    cyc(1);
    chk("clean_idle", phase, 0);
    chk("clean_count", trans_count, 1);
    chk("clean_no_fault", fault, 0);

    // Timeout in WAIT_ACK: fault exactly 100 cycles after entry
    uP_handshake_1 = 1'b1;
    cyc(3);
    chk("to_entry", phase, 1);
    cyc(99);
    chk("to_not_yet", phase, 1);
    cyc(1);
    chk("to_phase", phase, 4);
    chk("to_fault", fault, 1);
    chk("to_code", fault_code, 4);
    uP_handshake_1 = 1'b0;
    cyc(3);
    chk("to_code_held", fault_code, 4);
    clear_pulse();
    chk("to_clr_phase", phase, 0);
    chk("to_clr_fault", fault, 0);
    chk("to_clr_code", fault_code, 0);
    chk("to_count_kept", trans_count, 1);

    // Spurious ack, clear refused while ack high
    uP_handshake_2 = 1'b1;
    cyc(3);
    chk("spur_code", fault_code, 1);
    clear_pulse();
    chk("spur_clr_refused", phase, 4);
    chk("spur_code_kept", fault_code, 1);
    uP_handshake_2 = 1'b0;
    cyc(3);
    clear_pulse();
    chk("spur_clr_phase", phase, 0);
    chk("spur_clr_code", fault_code, 0);

    // Request withdrawn
    uP_handshake_1 = 1'b1;
    cyc(3);
    uP_handshake_1 = 1'b0;
    cyc(3);
    chk("wd_code", fault_code, 2);
    clear_pulse();
    chk("wd_clr", phase, 0);

    // Ack dropped early in WAIT_REQ_LOW
    uP_handshake_1 = 1'b1;
    cyc(3);
    uP_handshake_2 = 1'b1;
    cyc(3);
    chk("early_wrl", phase, 2);
    uP_handshake_2 = 1'b0;
    cyc(3);
    chk("early_phase", phase, 4);
    chk("early_code", fault_code, 3);
    chk("early_count", trans_count, 1);
    uP_handshake_1 = 1'b0;
    cyc(3);
    clear_pulse();
    chk("early_clr", phase, 0);

    // Counter wrap with a 4-bit counter
    do_reset();
    for (int i = 0; i < 15; i++) handshake();
    chk("wrap_15", trans_count, 15);
    handshake();
    chk("wrap_16", trans_count, 0);
    handshake();
    chk("wrap_17", trans_count, 1);

    // Asynchronous reset mid-transaction, observed before the next clk edge
    uP_handshake_1 = 1'b1;
    cyc(3);
    chk("ar_wait_ack", phase, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_phase", phase, 0);
    chk("ar_count", trans_count, 0);
    chk("ar_req_sync", hs_req_sync, 0);
    chk("ar_fault", fault, 0);
    chk("ar_code", fault_code, 0);
    uP_handshake_1 = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);

`ifdef HS_WATCHDOG_LOG_EN
    chk("log_empty_rst", log_empty, 1);
    // code 1
    uP_handshake_2 = 1'b1; cyc(3);
    uP_handshake_2 = 1'b0; cyc(3); clear_pulse();
    // code 2
    uP_handshake_1 = 1'b1; cyc(3);
    uP_handshake_1 = 1'b0; cyc(3); clear_pulse();
    // code 3
    uP_handshake_1 = 1'b1; cyc(3);
    uP_handshake_2 = 1'b1; cyc(3);
    uP_handshake_2 = 1'b0; cyc(3);
    uP_handshake_1 = 1'b0; cyc(3); clear_pulse();
    // code 4
    uP_handshake_1 = 1'b1; cyc(103);
    chk("log_to_code", fault_code, 4);
    uP_handshake_1 = 1'b0; cyc(3); clear_pulse();
    // code 1 again, overwrites the oldest
    uP_handshake_2 = 1'b1; cyc(3);
    uP_handshake_2 = 1'b0; cyc(3); clear_pulse();
    chk("log_not_empty", log_empty, 0);
    chk("log_e0", log_data, {3'd2, 4'd0});
    log_rd = 1'b1; cyc(1); log_rd = 1'b0;
    chk("log_e1", log_data, {3'd3, 4'd0});
    log_rd = 1'b1; cyc(1); log_rd = 1'b0;
    chk("log_e2", log_data, {3'd4, 4'd0});
    log_rd = 1'b1; cyc(1); log_rd = 1'b0;
    chk("log_e3", log_data, {3'd1, 4'd0});
    log_rd = 1'b1; cyc(1); log_rd = 1'b0;
    chk("log_empty_end", log_empty, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
